// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : change_dispenser
//  Purpose  : Pays out change after a sale, one coin per valid/ready
//             handshake, largest available denomination first. Keeps its own
//             per-denomination coin stock, which the coin path refills.
//  Ports    : clock, reset (async, active-low)
//             start, paid[15:0], cost[15:0]  - transaction request
//             deposit_valid, deposit_coin[1:0] - stock refill (one coin/cycle)
//             coin_valid, coin_type[1:0], coin_ready - hopper handshake
//             busy, done, error, err_code[1:0], remaining[15:0] - status
//             stock_500/1000/2000/5000[3:0] - current coin stock
//  Coding   : 00=5, 01=10, 10=20, 11=50 value units
//  Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter logic [3:0] INIT_STOCK = 4'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] paid,
  input  logic [15:0] cost,
  input  logic        deposit_valid,
  input  logic [1:0]  deposit_coin,
  output logic        coin_valid,
  output logic [1:0]  coin_type,
  input  logic        coin_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] remaining,
  output logic [3:0]  stock_500,
  output logic [3:0]  stock_1000,
  output logic [3:0]  stock_2000,
  output logic [3:0]  stock_5000
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERPAID = 2'b01;
  localparam logic [1:0] ERR_NO_CHANGE = 2'b10;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        underpaid;
  logic [15:0] stock_all;
  logic        sel_found;
  logic [1:0]  sel_type;
  logic        handshake;
  logic        busy_d;
  logic        coin_valid_d;
  logic        done_d;
  logic        error_d;

  function automatic logic [15:0] coin_value(input logic [1:0] kind);
    case (kind)
      2'b00:   coin_value = 16'd5;
      2'b01:   coin_value = 16'd10;
      2'b10:   coin_value = 16'd20;
      default: coin_value = 16'd50;
    endcase
  endfunction

  // coin_valid is high exactly while in ISSUE, so ready alone completes it.
  assign handshake = (state == S_ISSUE) && coin_ready;

  // Greedy pick: largest coin that fits the remainder and is in stock.
  always_comb begin
    sel_found = 1'b0;
    sel_type  = 2'b00;
    if (stock_all[15:12] != 4'd0 && remaining >= 16'd50) begin
      sel_found = 1'b1;
      sel_type  = 2'b11;
    end else if (stock_all[11:8] != 4'd0 && remaining >= 16'd20) begin
      sel_found = 1'b1;
      sel_type  = 2'b10;
    end else if (stock_all[7:4] != 4'd0 && remaining >= 16'd10) begin
      sel_found = 1'b1;
      sel_type  = 2'b01;
    end else if (stock_all[3:0] != 4'd0 && remaining >= 16'd5) begin
      sel_found = 1'b1;
      sel_type  = 2'b00;
    end
  end

  // State register; the status outputs are registered alongside it so that
  // they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= busy_d;
      coin_valid <= coin_valid_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // CHECK acts on the paid/cost comparison captured with start, giving the
  // one-cycle decision step between acceptance and the first selection.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CHECK;
      S_CHECK:  next_state = underpaid ? S_FAIL : S_SELECT;
      S_SELECT: begin
        if (remaining == 16'd0)  next_state = S_FIN;
        else if (sel_found)      next_state = S_ISSUE;
        else                     next_state = S_FAIL;
      end
      S_ISSUE:  if (coin_ready) next_state = S_SELECT;
      S_FIN:    next_state = S_IDLE;
      S_FAIL:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (next_state != S_IDLE);
    coin_valid_d = (next_state == S_ISSUE);
    done_d       = (next_state == S_FIN);
    error_d      = (next_state == S_FAIL);
  end

  // Transaction datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underpaid <= 1'b0;
      remaining <= 16'd0;
      err_code  <= ERR_NONE;
      coin_type <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            underpaid <= (paid < cost);
            // Subtract only when it cannot wrap.
            remaining <= (paid < cost) ? 16'd0 : (paid - cost);
            err_code  <= ERR_NONE;
          end
        end
        S_CHECK: begin
          if (underpaid) err_code <= ERR_UNDERPAID;
        end
        S_SELECT: begin
          if (remaining != 16'd0) begin
            if (sel_found) coin_type <= sel_type;
            else           err_code  <= ERR_NO_CHANGE;
          end
        end
        S_ISSUE: begin
          if (coin_ready) remaining <= remaining - coin_value(coin_type);
        end
        default: ;
      endcase
    end
  end

  // Per-denomination stock: refill saturates at 15; a refill and a payout of
  // the same coin in one cycle cancel out.
  for (genvar g = 0; g < 4; g++) begin : g_stock
    logic [3:0] count;
    logic       inc;
    logic       dec;

    assign inc = deposit_valid && (deposit_coin == 2'(g));
    assign dec = handshake && (coin_type == 2'(g));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        count <= INIT_STOCK;
      end else if (inc && !dec) begin
        count <= (count == 4'd15) ? 4'd15 : count + 4'd1;
      end else if (dec && !inc) begin
        count <= count - 4'd1;
      end
    end

    assign stock_all[4*g +: 4] = count;
  end

  assign stock_500  = stock_all[3:0];
  assign stock_1000 = stock_all[7:4];
  assign stock_2000 = stock_all[11:8];
  assign stock_5000 = stock_all[15:12];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_change_dispenser
//  Purpose  : Directed bench for change_dispenser. A greedy reference model
//             pushes expected coins into a queue when a transaction starts;
//             a monitor pops and compares them on each hopper handshake.
//             A second instance starts with empty stock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset;

  // Instance with default stock
  logic        start, deposit_valid, coin_ready;
  logic [15:0] paid, cost;
  logic [1:0]  deposit_coin;
  logic        coin_valid, busy, done, error;
  logic [1:0]  coin_type, err_code;
  logic [15:0] remaining;
  logic [3:0]  s500, s1000, s2000, s5000;

  // Instance starting with empty stock
  logic        start_z, deposit_valid_z, coin_ready_z;
  logic [15:0] paid_z, cost_z;
  logic [1:0]  deposit_coin_z;
  logic        coin_valid_z, busy_z, done_z, error_z;
  logic [1:0]  coin_type_z, err_code_z;
  logic [15:0] remaining_z;
  logic [3:0]  s500_z, s1000_z, s2000_z, s5000_z;

  int vectors     = 0;
  int miscompares = 0;
  int q_a[$];
  int q_z[$];
  int mstock_a[4];
  int mstock_z[4];
  int e_err, e_rem, pop_a, pop_z;
  bit got;

  change_dispenser dut (
    .clock(clock), .reset(reset), .start(start), .paid(paid), .cost(cost),
    .deposit_valid(deposit_valid), .deposit_coin(deposit_coin),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .remaining(remaining), .stock_500(s500), .stock_1000(s1000),
    .stock_2000(s2000), .stock_5000(s5000)
  );

  change_dispenser #(.INIT_STOCK(4'd0)) dut_z (
    .clock(clock), .reset(reset), .start(start_z), .paid(paid_z), .cost(cost_z),
    .deposit_valid(deposit_valid_z), .deposit_coin(deposit_coin_z),
    .coin_valid(coin_valid_z), .coin_type(coin_type_z), .coin_ready(coin_ready_z),
    .busy(busy_z), .done(done_z), .error(error_z), .err_code(err_code_z),
    .remaining(remaining_z), .stock_500(s500_z), .stock_1000(s1000_z),
    .stock_2000(s2000_z), .stock_5000(s5000_z)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Greedy reference: pushes expected coins and consumes model stock.
  task automatic model_txn(input int which, input int p, input int c,
                           output int err, output int rem);
    int vals[4];
    int pick;
    vals[0] = 5; vals[1] = 10; vals[2] = 20; vals[3] = 50;
    err = 0;
    rem = 0;
    if (p < c) begin
      err = 1;
    end else begin
      rem = p - c;
      while (rem > 0 && err == 0) begin
        pick = -1;
        for (int k = 3; k >= 0; k--) begin
          if (pick < 0 && vals[k] <= rem &&
              ((which == 0) ? mstock_a[k] : mstock_z[k]) > 0)
            pick = k;
        end
        if (pick < 0) begin
          err = 2;
        end else begin
          if (which == 0) begin q_a.push_back(pick); mstock_a[pick]--; end
          else            begin q_z.push_back(pick); mstock_z[pick]--; end
          rem -= vals[pick];
        end
      end
    end
  endtask

  task automatic check_stocks_a(input string tag);
    chk({tag, "_s500"},  s500,  mstock_a[0]);
    chk({tag, "_s1000"}, s1000, mstock_a[1]);
    chk({tag, "_s2000"}, s2000, mstock_a[2]);
    chk({tag, "_s5000"}, s5000, mstock_a[3]);
  endtask

  task automatic check_stocks_z(input string tag);
    chk({tag, "_s500"},  s500_z,  mstock_z[0]);
    chk({tag, "_s1000"}, s1000_z, mstock_z[1]);
    chk({tag, "_s2000"}, s2000_z, mstock_z[2]);
    chk({tag, "_s5000"}, s5000_z, mstock_z[3]);
  endtask

  task automatic wait_end_a(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || error) begin seen = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_end_z(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_z || error_z) begin seen = 1'b1; break; end
      tick();
    end
  endtask

  // Scoreboard monitors: compare each handshaken coin against the queue.
  always @(negedge clock) begin
    if (reset && coin_valid && coin_ready) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL coin_a_extra: observed coin %0d expected none", coin_type);
      end else begin
        pop_a = q_a.pop_front();
        chk("coin_a", coin_type, pop_a);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && coin_valid_z && coin_ready_z) begin
      if (q_z.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL coin_z_extra: observed coin %0d expected none", coin_type_z);
      end else begin
        pop_z = q_z.pop_front();
        chk("coin_z", coin_type_z, pop_z);
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 0; paid = 0; cost = 0; deposit_valid = 0; deposit_coin = 0; coin_ready = 0;
    start_z = 0; paid_z = 0; cost_z = 0; deposit_valid_z = 0; deposit_coin_z = 0; coin_ready_z = 0;
    for (int k = 0; k < 4; k++) begin mstock_a[k] = 5; mstock_z[k] = 0; end
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_done", done, 0);
    check_stocks_a("rst");
    check_stocks_z("rst_z");

    // Normal change: 85 - 15 = 70 -> 50, 20
    coin_ready = 1; paid = 85; cost = 15; start = 1;
    model_txn(0, 85, 15, e_err, e_rem);
    tick(); start = 0;                       // edge N
    chk("norm_busy", busy, 1);
    tick();
    chk("norm_valid_n1", coin_valid, 0);
    tick();
    chk("norm_valid_n2", coin_valid, 1);
    chk("norm_type_n2", coin_type, 3);
    wait_end_a(got);
    chk("norm_end_seen", got, 1);
    chk("norm_done", done, 1);
    chk("norm_remaining", remaining, e_rem);
    chk("norm_err_code", err_code, e_err);
    check_stocks_a("norm");
    tick();
    chk("norm_done_pulse", done, 0);
    chk("norm_busy_after", busy, 0);
    chk("norm_q_empty", q_a.size(), 0);

    // Stall on the first coin for three cycles
    coin_ready = 0; start = 1;
    model_txn(0, 85, 15, e_err, e_rem);
    tick(); start = 0;
    tick();
    tick();
    chk("stall_valid", coin_valid, 1);
    chk("stall_type", coin_type, 3);
    chk("stall_s5000", s5000, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid_hold", coin_valid, 1);
      chk("stall_type_hold", coin_type, 3);
      chk("stall_s5000_hold", s5000, 4);
    end
    coin_ready = 1;
    wait_end_a(got);
    chk("stall_end_seen", got, 1);
    chk("stall_done", done, 1);
    chk("stall_remaining", remaining, e_rem);
    check_stocks_a("stall");
    tick();
    chk("stall_q_empty", q_a.size(), 0);

    // Underpay
    paid = 10; cost = 20; start = 1;
    model_txn(0, 10, 20, e_err, e_rem);
    tick(); start = 0;
    chk("under_error_n", error, 0);
    tick();
    chk("under_error", error, 1);
    chk("under_err_code", err_code, e_err);
    chk("under_remaining", remaining, e_rem);
    chk("under_valid", coin_valid, 0);
    tick();
    chk("under_error_pulse", error, 0);
    chk("under_busy", busy, 0);
    chk("under_err_hold", err_code, 1);

    // Deposit 2000 in the same cycle a 2000 coin handshakes
    paid = 20; cost = 0; start = 1;
    model_txn(0, 20, 0, e_err, e_rem);
    tick(); start = 0;
    tick();
    tick();
    chk("sim_type", coin_type, 2);
    deposit_valid = 1; deposit_coin = 2;
    mstock_a[2] = (mstock_a[2] < 15) ? mstock_a[2] + 1 : 15;
    tick();
    deposit_valid = 0;
    chk("sim_s2000", s2000, mstock_a[2]);
    wait_end_a(got);
    chk("sim_end_seen", got, 1);
    chk("sim_done", done, 1);
    check_stocks_a("sim");
    tick();

    // Saturating refill of 5000
    deposit_valid = 1; deposit_coin = 3;
    for (int i = 0; i < 14; i++) begin
      tick();
      mstock_a[3] = (mstock_a[3] < 15) ? mstock_a[3] + 1 : 15;
    end
    deposit_valid = 0;
    tick();
    chk("sat_s5000", s5000, 15);
    check_stocks_a("sat");

    // start while busy is ignored
    paid = 50; cost = 0; start = 1;
    model_txn(0, 50, 0, e_err, e_rem);
    tick(); start = 0;
    tick();
    start = 1; paid = 5; cost = 0;
    tick(); start = 0;
    wait_end_a(got);
    chk("busy_end_seen", got, 1);
    chk("busy_done", done, 1);
    chk("busy_remaining", remaining, e_rem);
    check_stocks_a("busy");
    tick();
    chk("busy_idle", busy, 0);
    chk("busy_q_empty", q_a.size(), 0);

    // Cannot make change on the empty-stock instance
    deposit_valid_z = 1; deposit_coin_z = 2;
    tick();
    deposit_coin_z = 3;
    tick();
    deposit_valid_z = 0;
    mstock_z[2] = 1; mstock_z[3] = 1;
    check_stocks_z("nc_dep");
    coin_ready_z = 1; paid_z = 60; cost_z = 25; start_z = 1;
    model_txn(1, 60, 25, e_err, e_rem);
    tick(); start_z = 0;
    wait_end_z(got);
    chk("nc_end_seen", got, 1);
    chk("nc_error", error_z, 1);
    chk("nc_err_code", err_code_z, e_err);
    chk("nc_remaining", remaining_z, e_rem);
    chk("nc_valid", coin_valid_z, 0);
    check_stocks_z("nc");
    tick();
    chk("nc_error_pulse", error_z, 0);
    chk("nc_busy", busy_z, 0);
    chk("nc_q_empty", q_z.size(), 0);

    // Reset in the middle of a stalled coin offer
    coin_ready = 0; paid = 50; cost = 0; start = 1;
    tick(); start = 0;
    tick();
    tick();
    chk("mid_valid_before", coin_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid", coin_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_remaining", remaining, 0);
    chk("mid_s5000", s5000, 5);
    chk("mid_z_s2000", s2000_z, 0);
    q_a.delete();
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
